// File: rtl/db_mem_responder.sv
// rtl/db_mem_responder.sv - data-bus responder: word RAM, io register window, programmable wait states
// Optional DB_RESP_ALIGN_CHECK_EN: misaligned accesses are blocked, read 0xDEADBEEF and set sticky err.
module db_mem_responder #(
  parameter int ADDR_W     = 12,
  parameter int READ_WAIT  = 1,
  parameter int WRITE_WAIT = 0
) (
  input  logic        clk,
  input  logic        res,
  input  logic        db_re,
  input  logic        db_we,
  input  logic        db_io,
  input  logic [31:0] db_addr,
  input  logic [31:0] db_dataIn,
  output logic [31:0] db_dataOut,
  output logic        db_ready,
  output logic        err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] RD_WAIT = READ_WAIT[3:0];
  localparam logic [3:0] WR_WAIT = WRITE_WAIT[3:0];

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic [31:0]         r_addr;
  logic [31:0]         r_wdata;
  logic                r_io;
  logic                r_we;
  logic [31:0]         r_cycles;
  logic [31:0]         r_scratch;
  logic [31:0]         r_lastadr;
  logic [31:0]         r_mem [DEPTH];

  logic                w_req;
  logic [3:0]          w_load;
  logic                w_mis;
  logic                w_commit;
  logic [ADDR_W-1:0]   w_idx;
  logic [31:0]         w_rdata;

  assign w_req    = db_re | db_we;
  assign w_load   = db_we ? WR_WAIT : RD_WAIT;
  assign w_idx    = r_addr[ADDR_W+1:2];
  assign w_commit = (r_state == S_ACK) && r_we && !w_mis;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_req) w_next = (w_load != 4'd0) ? S_WAIT : S_ACK;
      S_WAIT: if (r_cnt <= 4'd1) w_next = S_ACK;
      S_ACK:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request fields are captured only in IDLE; WAIT/ACK run on the latched copy.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_io    <= 1'b0;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_req) begin
        r_addr  <= db_addr;
        r_wdata <= db_dataIn;
        r_io    <= db_io;
        r_we    <= db_we;
        r_cnt   <= w_load;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_cycles  <= 32'd0;
      r_scratch <= 32'd0;
      r_lastadr <= 32'd0;
    end else begin
      r_cycles <= r_cycles + 32'd1;
      if (w_commit && r_io && r_addr[3:2] == 2'd1) r_scratch <= r_wdata;
      if (w_commit && !r_io) r_lastadr <= r_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit && !r_io) r_mem[w_idx] <= r_wdata;
  end

  always_comb begin
    w_rdata = 32'd0;
    if (w_mis) begin
      w_rdata = 32'hDEADBEEF;
    end else if (r_io) begin
      case (r_addr[3:2])
        2'd0:    w_rdata = r_cycles;
        2'd1:    w_rdata = r_scratch;
        2'd2:    w_rdata = r_lastadr;
        default: w_rdata = 32'd0;
      endcase
    end else begin
      w_rdata = r_mem[w_idx];
    end
  end

  assign db_ready   = (r_state == S_ACK);
  assign db_dataOut = (r_state == S_ACK && !r_we) ? w_rdata : 32'd0;

`ifdef DB_RESP_ALIGN_CHECK_EN
  logic r_err;

  assign w_mis = |r_addr[1:0];
  assign err   = r_err;

  always_ff @(posedge clk or negedge res) begin
    if (!res) r_err <= 1'b0;
    else if (r_state == S_ACK && w_mis) r_err <= 1'b1;
  end
`else
  assign w_mis = 1'b0;
  assign err   = 1'b0;
`endif

endmodule

// File: tb/tb_db_mem_responder.sv
// tb/tb_db_mem_responder.sv - directed and random checks of db_mem_responder against a reference model
module tb_db_mem_responder;

  localparam int AW = 8;
  localparam int RW = 2;
  localparam int WW = 0;
`ifdef DB_RESP_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic        db_re = 1'b0;
  logic        db_we = 1'b0;
  logic        db_io = 1'b0;
  logic [31:0] db_addr = 32'd0;
  logic [31:0] db_dataIn = 32'd0;
  logic [31:0] db_dataOut;
  logic        db_ready;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_mem [2**AW];
  logic [31:0] m_scratch = 32'd0;
  logic [31:0] m_lastadr = 32'd0;
  logic        m_err = 1'b0;
  int unsigned tb_cyc = 0;

  db_mem_responder #(.ADDR_W(AW), .READ_WAIT(RW), .WRITE_WAIT(WW)) dut (
    .clk(clk), .res(res), .db_re(db_re), .db_we(db_we), .db_io(db_io),
    .db_addr(db_addr), .db_dataIn(db_dataIn), .db_dataOut(db_dataOut),
    .db_ready(db_ready), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge res) begin
    if (!res) tb_cyc <= 0;
    else      tb_cyc <= tb_cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic io, input logic [31:0] a, input int unsigned cyc);
    if (ALIGN && a[1:0] != 2'd0) return 32'hDEADBEEF;
    if (io) begin
      case (a[3:2])
        2'd0:    return cyc;
        2'd1:    return m_scratch;
        2'd2:    return m_lastadr;
        default: return 32'd0;
      endcase
    end
    return m_mem[a[AW+1:2]];
  endfunction

  task automatic m_write(input logic io, input logic [31:0] a, input logic [31:0] d);
    if (ALIGN && a[1:0] != 2'd0) begin
      m_err = 1'b1;
      return;
    end
    if (io) begin
      if (a[3:2] == 2'd1) m_scratch = d;
    end else begin
      m_mem[a[AW+1:2]] = d;
      m_lastadr = a;
    end
  endtask

  // Called at a negedge; returns at the negedge of the ready cycle (plus one idle cycle unless hold).
  task automatic xfer(input logic re, input logic we, input logic io, input logic [31:0] addr,
                      input logic [31:0] data, input int exp_lat, input bit hold,
                      output logic [31:0] rd, output int unsigned cyc);
    int lat = 0;
    bit got = 0;
    db_re = re; db_we = we; db_io = io; db_addr = addr; db_dataIn = data;
    rd = 32'd0;
    cyc = 0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (db_ready) got = 1;
      else chk("dout_zero_when_not_ready", db_dataOut, 32'd0);
    end
    chk("ready_seen", {31'd0, got}, 32'd1);
    chk("latency", lat, exp_lat);
    rd  = db_dataOut;
    cyc = tb_cyc;
    if (!hold) begin
      db_re = 1'b0; db_we = 1'b0;
      @(negedge clk);
      chk("ready_one_cycle", {31'd0, db_ready}, 32'd0);
    end
  endtask

  task automatic mwrite(input logic io, input logic [31:0] a, input logic [31:0] d, input bit both);
    logic [31:0] rd;
    int unsigned cyc;
    xfer(both, 1'b1, io, a, d, 1 + WW, 1'b0, rd, cyc);
    chk("write_dout_zero", rd, 32'd0);
    m_write(io, a, d);
    chk("err_after_write", {31'd0, err}, {31'd0, m_err});
  endtask

  task automatic mread(input logic io, input logic [31:0] a, input int exp_lat, input bit hold,
                       output logic [31:0] rd, output int unsigned cyc);
    xfer(1'b1, 1'b0, io, a, 32'd0, exp_lat, hold, rd, cyc);
    chk("read_data", rd, m_read(io, a, cyc));
    if (ALIGN && a[1:0] != 2'd0) m_err = 1'b1;
  endtask

  initial begin
    logic [31:0] rd, rd2, old;
    int unsigned c1, c2;

    repeat (3) @(negedge clk);
    chk("reset_ready", {31'd0, db_ready}, 32'd0);
    chk("reset_dout", db_dataOut, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    res = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 2**AW; i++) mwrite(1'b0, i * 4, $urandom, 1'b0);

    // Io window: scratch, lastadr, reserved, cycle counter
    mread(1'b1, 32'h4, 1 + RW, 1'b0, rd, c1);
    mwrite(1'b1, 32'h4, 32'h0000CAFE, 1'b0);
    mread(1'b1, 32'h4, 1 + RW, 1'b0, rd, c1);
    chk("scratch_cafe", rd, 32'h0000CAFE);
    mwrite(1'b0, 32'h40, 32'h12345678, 1'b0);
    mread(1'b0, 32'h40, 1 + RW, 1'b0, rd, c1);
    chk("ram_12345678", rd, 32'h12345678);
    mread(1'b1, 32'h8, 1 + RW, 1'b0, rd, c1);
    chk("lastadr_40", rd, 32'h40);
    mread(1'b1, 32'hC, 1 + RW, 1'b0, rd, c1);
    mwrite(1'b1, 32'h0, 32'h55555555, 1'b0);
    mread(1'b1, 32'h0, 1 + RW, 1'b0, rd, c1);
    repeat (5) @(negedge clk);
    mread(1'b1, 32'h0, 1 + RW, 1'b0, rd2, c2);
    chk("cycles_delta", rd2 - rd, c2 - c1);

    // Both strobes high is a write
    mwrite(1'b0, 32'h44, 32'hA5A5A5A5, 1'b1);
    mread(1'b0, 32'h44, 1 + RW, 1'b0, rd, c1);
    chk("both_is_write", rd, 32'hA5A5A5A5);

    // Reset during a write ACK and during a read WAIT: nothing completes, RAM keeps old value
    old = m_mem[4];
    db_we = 1'b1; db_addr = 32'h10; db_dataIn = ~old;
    @(posedge clk); #1 res = 1'b0;
    @(negedge clk);
    chk("rst_ack_ready", {31'd0, db_ready}, 32'd0);
    chk("rst_scratch_dout", db_dataOut, 32'd0);
    db_we = 1'b0; res = 1'b1;
    m_scratch = 32'd0; m_lastadr = 32'd0; m_err = 1'b0;
    @(negedge clk);
    db_re = 1'b1; db_addr = 32'h20;
    @(posedge clk); @(posedge clk); #1 res = 1'b0;
    @(negedge clk);
    chk("rst_wait_ready", {31'd0, db_ready}, 32'd0);
    db_re = 1'b0; res = 1'b1;
    @(negedge clk);
    mread(1'b0, 32'h10, 1 + RW, 1'b0, rd, c1);
    chk("rst_old_value", rd, old);
    mread(1'b1, 32'h4, 1 + RW, 1'b0, rd, c1);
    mread(1'b1, 32'h8, 1 + RW, 1'b0, rd, c1);

    // Back-to-back reads with db_re held; address changes at each ready
    mread(1'b0, 32'h100, 1 + RW, 1'b1, rd, c1);
    for (int i = 1; i < 4; i++) mread(1'b0, 32'h100 + i * 4, 2 + RW, 1'b1, rd, c1);
    db_re = 1'b0;
    @(negedge clk);
    chk("b2b_no_extra_ready", {31'd0, db_ready}, 32'd0);

    // Random traffic with address aliasing through the upper bits
    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      a = {$urandom_range(0, 32'h003FFFFF), 8'($urandom), 2'b00};
      case ($urandom_range(0, 3))
        0: mwrite(1'b0, a, $urandom, 1'($urandom));
        1: mread(1'b0, a, 1 + RW, 1'b0, rd, c1);
        2: mwrite(1'b1, a, $urandom, 1'b0);
        default: mread(1'b1, a, 1 + RW, 1'b0, rd, c1);
      endcase
    end

    // Misaligned accesses
    mwrite(1'b0, 32'h41, 32'h0BADF00D, 1'b0);
    mread(1'b0, 32'h40, 1 + RW, 1'b0, rd, c1);
    mread(1'b0, 32'h42, 1 + RW, 1'b0, rd, c1);
    chk("err_final", {31'd0, err}, {31'd0, m_err});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
